// File: rtl/gray_seq_ctrl.sv
// Gray-code run sequencer: walks a binary index up/down over a programmed run and
// streams {bi, Gray(bi)} over valid/ready. Optional GRAY_CHECK_EN adds a sticky err output.
module gray_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] len,
    input  logic             ready,
    output logic [WIDTH-1:0] bi,
    output logic [WIDTH-1:0] gray,
    output logic             valid,
    output logic             busy,
    output logic             done
`ifdef GRAY_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic             dir_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] bi_q, gray_q;
    logic             valid_q, busy_q, done_q;

    logic [WIDTH-1:0] bi_nxt_d, gray_nxt_d;
    logic [WIDTH:0]   rem_init_d;
    logic             xfer_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray is derived from the next index so the registered pair always agrees.
    always_comb begin
        bi_nxt_d   = dir_q ? (bi_q - WIDTH'(1)) : (bi_q + WIDTH'(1));
        gray_nxt_d = to_gray(bi_nxt_d);
        rem_init_d = (len == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, len};
        xfer_d     = valid_q & ready;
    end

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q, err_q;
    logic [WIDTH-1:0] diff_d;
    logic             onehot_d;

    always_comb begin
        diff_d   = prev_q ^ gray_q;
        onehot_d = (diff_d != '0) && ((diff_d & (diff_d - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            have_prev_q <= 1'b0;
        end else if (state_q == S_RUN && xfer_d) begin
            if (have_prev_q && !onehot_d)
                err_q <= 1'b1;
            prev_q      <= gray_q;
            have_prev_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            bi_q    <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        dir_q   <= dir;
                        rem_q   <= rem_init_d;
                        bi_q    <= first;
                        gray_q  <= to_gray(first);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (xfer_d) begin
                        if (rem_q == (WIDTH+1)'(1)) begin
                            // Last code accepted: bi/gray keep their final values.
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bi_q   <= bi_nxt_d;
                            gray_q <= gray_nxt_d;
                            rem_q  <= rem_q - (WIDTH+1)'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bi    = bi_q;
    assign gray  = gray_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl: codes checked through a scoreboard queue,
// run timing and reset behaviour checked inline.
module tb_gray_seq_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, start, dir, ready;
    logic [W-1:0] first, len;
    logic [W-1:0] bi, gray;
    logic         valid, busy, done;
`ifdef GRAY_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    logic [2*W-1:0] sb_q[$];

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .first(first), .len(len),
        .ready(ready), .bi(bi), .gray(gray), .valid(valid), .busy(busy), .done(done)
`ifdef GRAY_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected codes for the run, then issues start for one edge.
    task automatic run_start(input logic d, input logic [W-1:0] f, input logic [W-1:0] l);
        int n;
        logic [W-1:0] b;
        n = (l == 0) ? (1 << W) : int'(l);
        b = f;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({b, b ^ (b >> 1)});
            b = d ? b - 1'b1 : b + 1'b1;
        end
        dir = d; first = f; len = l; start = 1'b1;
        tick();
        start = 1'b0; dir = ~d; first = ~f; len = l + 4'd3;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
            tick();
        end
        if (k != 0) tick();
    endtask

    // Transfer monitor: a handshake seen at negedge completes at the next posedge.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && valid && ready) begin
                xfers++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_xfer", {bi, gray}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_bi", bi, e[2*W-1:W]);
                    check("sb_gray", gray, e[W-1:0]);
                end
            end
        end
    end

    initial begin
        int k, dk, vc, x0;
        int pat[5];
        logic [W-1:0] sb, sg;
        pat = '{1, 0, 0, 1, 1};

        // Reset held with start asserted
        rst = 1'b1; start = 1'b1; dir = 1'b0; first = 4'd5; len = 4'd3; ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_bi", bi, 0);
        check("rst_gray", gray, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0; start = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        check("idle_valid", valid, 0);
        check("idle_busy", busy, 0);
        check("idle_bi", bi, 0);
        tick();

        // Full up sweep, len=0 -> 16 codes
        x0 = xfers; ready = 1'b1;
        run_start(1'b0, 4'd0, 4'd0);
        vc = 0; dk = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("sweep_busy", busy, 1);
            if (valid) vc++;
            if (done && dk == 0) dk = k;
            tick();
        end
        check("sweep_valid_cycles", vc, 16);
        check("sweep_done_cycle", dk, 17);
        check("sweep_xfers", xfers - x0, 16);
        check("sweep_sb_empty", sb_q.size(), 0);

        // Wrap up 14,15,0,1
        x0 = xfers;
        run_start(1'b0, 4'd14, 4'd4);
        wait_done(20, dk);
        check("wrapup_done_cycle", dk, 5);
        @(negedge clk);
        check("wrapup_idle_busy", busy, 0);
        check("wrapup_idle_valid", valid, 0);
        check("wrapup_xfers", xfers - x0, 4);
        tick();

        // Wrap down 1,0,15 with backpressure
        x0 = xfers; ready = 1'b1;
        run_start(1'b1, 4'd1, 4'd3);
        sb = '0; sg = '0;
        for (k = 0; k < 5; k++) begin
            ready = pat[k][0];
            @(negedge clk);
            check("bp_valid", valid, 1);
            if (k == 1) begin sb = bi; sg = gray; end
            if (k == 2) begin
                check("bp_hold_bi", bi, sb);
                check("bp_hold_gray", gray, sg);
            end
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_xfers", xfers - x0, 3);
        check("bp_sb_empty", sb_q.size(), 0);
`ifdef GRAY_CHECK_EN
        check("err_clean", err, 0);
`endif
        tick(); tick();

        // Ignored start during RUN, then reset after 2nd transfer
        x0 = xfers;
        run_start(1'b0, 4'd3, 4'd8);
        start = 1'b1; first = 4'd9; dir = 1'b1;
        @(negedge clk);
        check("mid_bi0", bi, 3);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("mid_bi1_unaffected", bi, 4);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_bi2", bi, 5);
        tick();
        @(negedge clk);
        check("mrst_bi", bi, 0);
        check("mrst_gray", gray, 0);
        check("mrst_valid", valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_xfers", xfers - x0, 2);
        sb_q.delete();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("mrst_no_done", done, 0);
        tick();

        // Normal run after reset: 2,1
        x0 = xfers;
        run_start(1'b1, 4'd2, 4'd2);
        wait_done(20, dk);
        check("post_done_cycle", dk, 3);
        check("post_xfers", xfers - x0, 2);
        check("post_sb_empty", sb_q.size(), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
